// File: rtl/noc_pkg.sv
// Shared definitions for the NoC traffic generator: FSM states and flit field helpers.
package noc_pkg;

    localparam int unsigned SEQ_W = 16;
    localparam int unsigned IDX_W = 16;
    localparam int unsigned PAY_W = SEQ_W + IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_PAY,
        S_GAP,
        S_DONE
    } state_t;

    // Low 32 bits of a payload flit: sequence number above the flit index.
    function automatic logic [PAY_W-1:0] payload_word(input logic [SEQ_W-1:0] seq,
                                                      input logic [IDX_W-1:0] idx);
        return {seq, idx};
    endfunction

endpackage

// File: rtl/noc_packet_generator.sv
// Synthetic packet source: header + payload flits on a valid/ready link,
// with configurable length, inter-packet gap and packet count.
module noc_packet_generator #(
    parameter int FLIT_WIDTH = 34,
    parameter int DEST_WIDTH = 5,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int SRC_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [31:0]           cfg_num_pkts,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           pkt_count
);
    import noc_pkg::*;

    localparam logic [DEST_WIDTH-1:0] SRC_F = DEST_WIDTH'(SRC_ID);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEST_WIDTH-1:0] r_dest;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic [GAP_WIDTH-1:0]  r_gap;
    logic [GAP_WIDTH-1:0]  r_gcnt;
    logic [31:0]           r_num;
    logic [31:0]           r_pkt_count;
    logic [SEQ_W-1:0]      r_seq;
    logic                  r_stop_req;

    logic w_valid, w_last, w_xfer, w_eop, w_stop_any, w_finish, w_start_ok;

    always_comb begin
        w_valid    = (r_state == S_HEAD) || (r_state == S_PAY);
        w_last     = ((r_state == S_HEAD) && (r_len == LEN_WIDTH'(1))) ||
                     ((r_state == S_PAY)  && (r_idx == r_len - LEN_WIDTH'(1)));
        w_xfer     = w_valid && out_ready;
        w_eop      = w_xfer && w_last;
        // Stop seen at any point while busy (or with the starting pulse) is remembered.
        w_stop_any = r_stop_req || stop;
        w_finish   = ((r_num != '0) && ((r_pkt_count + 32'd1) == r_num)) || w_stop_any;
        w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nxt = S_HEAD;
            S_HEAD, S_PAY: begin
                if (w_eop) begin
                    if (w_finish)           w_state_nxt = S_DONE;
                    else if (r_gap == '0)   w_state_nxt = S_HEAD;
                    else                    w_state_nxt = S_GAP;
                end else if (w_xfer) begin
                    w_state_nxt = S_PAY;
                end
            end
            S_GAP: begin
                if (w_stop_any)                    w_state_nxt = S_DONE;
                else if (r_gcnt == GAP_WIDTH'(1))  w_state_nxt = S_HEAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dest      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_gap       <= '0;
            r_gcnt      <= '0;
            r_num       <= '0;
            r_pkt_count <= '0;
            r_seq       <= '0;
            r_stop_req  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_dest      <= cfg_dest;
                r_len       <= (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
                r_gap       <= cfg_gap;
                r_num       <= cfg_num_pkts;
                r_pkt_count <= '0;
                r_seq       <= '0;
                r_stop_req  <= stop;
            end else if (busy) begin
                r_stop_req  <= r_stop_req | stop;
            end

            if ((r_state == S_HEAD) && w_xfer)     r_idx <= LEN_WIDTH'(1);
            else if ((r_state == S_PAY) && w_xfer) r_idx <= r_idx + LEN_WIDTH'(1);

            if (w_eop) begin
                if (r_pkt_count != '1) r_pkt_count <= r_pkt_count + 32'd1;
                r_seq  <= r_seq + SEQ_W'(1);
                r_gcnt <= r_gap;
            end else if (r_state == S_GAP) begin
                r_gcnt <= r_gcnt - GAP_WIDTH'(1);
            end
        end
    end

    always_comb begin
        out_flit = '0;
        if (r_state == S_HEAD) begin
            out_flit[FLIT_WIDTH-1 -: DEST_WIDTH]            = r_dest;
            out_flit[FLIT_WIDTH-1-DEST_WIDTH -: DEST_WIDTH] = SRC_F;
            out_flit[SEQ_W-1:0]                             = r_seq;
        end else if (r_state == S_PAY) begin
            out_flit[PAY_W-1:0] = payload_word(r_seq, IDX_W'(r_idx));
        end
    end

    assign out_valid = w_valid;
    assign out_last  = w_last;
    assign busy      = (r_state == S_HEAD) || (r_state == S_PAY) || (r_state == S_GAP);
    assign done      = (r_state == S_DONE);
    assign pkt_count = r_pkt_count;

endmodule
